// File: rtl/pipeline_dmem_responder.sv
// Data-memory responder: latches one MEM-stage request, waits WAIT_CYCLES, performs a
// byte/half/word/double access on a 64-bit little-endian array and pulses dm_ready.
//
//   state | meaning
//   IDLE  | waiting for dm_rd_ctrl or dm_wr_ctrl to go nonzero
//   WAIT  | request latched, counting down wait states; access on the edge leaving WAIT
//   RESP  | dm_ready high for one cycle, dm_dout/dm_err valid
module pipeline_dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [63:0] BASE_ADDR   = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_din,
    input  logic [2:0]  dm_rd_ctrl,
    input  logic [2:0]  dm_wr_ctrl,
    output logic [63:0] dm_dout,
    output logic        dm_ready,
    output logic        dm_busy,
    output logic        dm_err
);

    localparam int          IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic [63:0] addr_q, din_q, dout_q;
    logic [2:0]  rd_q, wr_q;
    logic [7:0]  cnt_q;
    logic        err_q;

    logic        req, accept, access;
    logic [60:0] word_off;
    logic [IDXW-1:0] idx;
    logic [2:0]  lane;
    logic [1:0]  size_l2;
    logic        range_err, misal, req_err, we;
    logic [7:0]  base_en, byte_en;
    logic [63:0] rd_word, rd_shift, load_val, wr_data;

    logic [63:0] mem [DEPTH];

    assign req = (dm_rd_ctrl != 3'd0) || (dm_wr_ctrl != 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Address decode on the latched request; the byte lane always comes from the raw address.
    assign word_off  = 61'((addr_q - BASE_ADDR) >> 3);
    assign idx       = word_off[IDXW-1:0];
    assign lane      = addr_q[2:0];
    assign range_err = (addr_q < BASE_ADDR) || ({3'b000, word_off} >= 64'(DEPTH));

    always_comb begin
        size_l2 = 2'd3;
        if (rd_q != 3'd0) begin
            case (rd_q)
                3'd1, 3'd2: size_l2 = 2'd0;
                3'd3, 3'd4: size_l2 = 2'd1;
                3'd5, 3'd6: size_l2 = 2'd2;
                default:    size_l2 = 2'd3;
            endcase
        end else begin
            case (wr_q)
                3'd1:    size_l2 = 2'd0;
                3'd2:    size_l2 = 2'd1;
                3'd3:    size_l2 = 2'd2;
                default: size_l2 = 2'd3;
            endcase
        end
    end

    always_comb begin
        misal   = 1'b0;
        base_en = 8'hFF;
        case (size_l2)
            2'd0: begin misal = 1'b0;        base_en = 8'h01; end
            2'd1: begin misal = lane[0];     base_en = 8'h03; end
            2'd2: begin misal = |lane[1:0];  base_en = 8'h0F; end
            default: begin misal = |lane;    base_en = 8'hFF; end
        endcase
    end

    assign req_err = ((rd_q != 3'd0) && (wr_q != 3'd0)) || (wr_q >= 3'd5) || misal || range_err;
    assign we      = access && !req_err && (wr_q != 3'd0);
    assign byte_en = base_en << lane;
    assign wr_data = din_q << {lane, 3'b000};
    assign rd_word = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        load_val = 64'd0;
        case (rd_q)
            3'd1:    load_val = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'd2:    load_val = {56'd0,              rd_shift[7:0]};
            3'd3:    load_val = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_val = {48'd0,              rd_shift[15:0]};
            3'd5:    load_val = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'd6:    load_val = {32'd0,              rd_shift[31:0]};
            3'd7:    load_val = rd_shift;
            default: load_val = 64'd0;
        endcase
    end

    // Array has no reset; the write enable is qualified by state, so a reset in WAIT drops the store.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= 64'd0;
            din_q  <= 64'd0;
            rd_q   <= 3'd0;
            wr_q   <= 3'd0;
            cnt_q  <= 8'd0;
            dout_q <= 64'd0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= dm_addr;
                din_q  <= dm_din;
                rd_q   <= dm_rd_ctrl;
                wr_q   <= dm_wr_ctrl;
                cnt_q  <= WAIT_INIT;
            end else if ((state_q == ST_WAIT) && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (access) begin
                dout_q <= req_err ? 64'd0 : load_val;
                err_q  <= req_err;
            end else if (state_q == ST_RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    assign dm_ready = (state_q == ST_RESP);
    assign dm_busy  = (state_q != ST_IDLE);
    assign dm_dout  = dout_q;
    assign dm_err   = err_q;

endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Self-checking bench: two responders (no wait / 3 wait states with a nonzero base) checked
// against a byte-addressed reference memory.
module tb_pipeline_dmem_responder;

    localparam int          DEPTH  = 16;
    localparam int          WAIT_B = 3;
    localparam logic [63:0] BASE_B = 64'h1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [63:0] a_addr = '0, a_din = '0, a_dout, b_addr = '0, b_din = '0, b_dout;
    logic [2:0]  a_rd = '0, a_wr = '0, b_rd = '0, b_wr = '0;
    logic        a_ready, a_busy, a_err, b_ready, b_busy, b_err;

    pipeline_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(64'd0)) u_dut_a (
        .clk(clk), .reset(reset), .dm_addr(a_addr), .dm_din(a_din), .dm_rd_ctrl(a_rd),
        .dm_wr_ctrl(a_wr), .dm_dout(a_dout), .dm_ready(a_ready), .dm_busy(a_busy), .dm_err(a_err));

    pipeline_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_B), .BASE_ADDR(BASE_B)) u_dut_b (
        .clk(clk), .reset(reset), .dm_addr(b_addr), .dm_din(b_din), .dm_rd_ctrl(b_rd),
        .dm_wr_ctrl(b_wr), .dm_dout(b_dout), .dm_ready(b_ready), .dm_busy(b_busy), .dm_err(b_err));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model [0:1][0:DEPTH*8-1];

    function automatic int acc_size(input logic [2:0] rd, input logic [2:0] wr);
        int s;
        s = 8;
        if (rd != 3'd0) begin
            if (rd <= 3'd2) s = 1; else if (rd <= 3'd4) s = 2; else if (rd <= 3'd6) s = 4;
        end else begin
            if (wr == 3'd1) s = 1; else if (wr == 3'd2) s = 2; else if (wr == 3'd3) s = 4;
        end
        return s;
    endfunction

    // Reference: byte-addressed memory, loads assembled byte by byte and extended arithmetically.
    task automatic model_access(input int sel, input logic [2:0] rd, input logic [2:0] wr,
                                input logic [63:0] addr, input logic [63:0] din,
                                output logic [63:0] exp_dout, output logic exp_err);
        logic [63:0] base, off, v;
        int sz;
        base = (sel != 0) ? BASE_B : 64'd0;
        sz = acc_size(rd, wr);
        exp_dout = 64'd0;
        off = addr - base;
        exp_err = (rd != 0 && wr != 0) || (wr >= 3'd5) || ((addr % 64'(sz)) != 64'd0)
                  || (addr < base) || ((off / 64'd8) >= 64'(DEPTH));
        if (!exp_err) begin
            if (wr != 3'd0) begin
                for (int i = 0; i < sz; i++) model[sel][int'(off) + i] = din[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < sz; i++) v = v | (64'(model[sel][int'(off) + i]) << (8*i));
                if ((rd == 3'd1 || rd == 3'd3 || rd == 3'd5) && v[8*sz-1])
                    v = v | ~((64'd1 << (8*sz)) - 64'd1);
                exp_dout = v;
            end
        end
    endtask

    function automatic logic get_ready(input int sel); return (sel != 0) ? b_ready : a_ready; endfunction
    function automatic logic get_busy(input int sel);  return (sel != 0) ? b_busy  : a_busy;  endfunction
    function automatic logic get_err(input int sel);   return (sel != 0) ? b_err   : a_err;   endfunction
    function automatic logic [63:0] get_dout(input int sel); return (sel != 0) ? b_dout : a_dout; endfunction

    task automatic drive(input int sel, input logic [2:0] rd, input logic [2:0] wr,
                         input logic [63:0] addr, input logic [63:0] din);
        if (sel == 0) begin a_rd = rd; a_wr = wr; a_addr = addr; a_din = din; end
        else          begin b_rd = rd; b_wr = wr; b_addr = addr; b_din = din; end
    endtask

    // One request, ctrl held for the accept edge only. lat = edges from accept (inclusive) to ready.
    task automatic do_req(input int sel, input logic [2:0] rd, input logic [2:0] wr,
                          input logic [63:0] addr, input logic [63:0] din,
                          output logic [63:0] dout, output logic err, output int lat,
                          output logic busy1, output logic ready_after);
        lat = -1; dout = 'x; err = 'x; ready_after = 1'b1;
        @(negedge clk);
        drive(sel, rd, wr, addr, din);
        @(posedge clk);
        @(negedge clk);
        busy1 = get_busy(sel);
        drive(sel, 3'd0, 3'd0, addr, din);
        for (int e = 1; e <= 40; e++) begin
            if (e > 1) @(negedge clk);
            if (get_ready(sel)) begin
                lat = e; dout = get_dout(sel); err = get_err(sel);
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            ready_after = get_ready(sel) | get_err(sel);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({a_dout, a_ready, a_busy, a_err} !== 67'd0) begin
            n_fail++; $display("FAIL reset_a: got dout=%h rdy=%b busy=%b err=%b want all 0", a_dout, a_ready, a_busy, a_err);
        end
        n_tests++;
        if ({b_dout, b_ready, b_busy, b_err} !== 67'd0) begin
            n_fail++; $display("FAIL reset_b: got dout=%h rdy=%b busy=%b err=%b want all 0", b_dout, b_ready, b_busy, b_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_init;
        logic [63:0] d, ed, din, base;
        logic e, ee, b1, ra;
        int lat, bad;
        bad = 0;
        for (int sel = 0; sel < 2; sel++) begin
            base = (sel != 0) ? BASE_B : 64'd0;
            for (int w = 0; w < DEPTH; w++) begin
                din = {$urandom, $urandom};
                model_access(sel, 3'd0, 3'd4, base + 64'(8*w), din, ed, ee);
                do_req(sel, 3'd0, 3'd4, base + 64'(8*w), din, d, e, lat, b1, ra);
                if (e !== 1'b0 || lat != (sel != 0 ? WAIT_B : 0) + 2) bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL init_fill: got %0d bad stores want 0", bad); end
    endtask

    task automatic test_sd_ld;
        logic [63:0] d, ed;
        logic e, ee, b1, ra;
        int lat;
        model_access(0, 3'd0, 3'd4, 64'h10, 64'h8877665544332211, ed, ee);
        do_req(0, 3'd0, 3'd4, 64'h10, 64'h8877665544332211, d, e, lat, b1, ra);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL sd_latency: got %0d want 2", lat); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL sd_err: got %b want 0", e); end
        n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL sd_busy: got %b want 1", b1); end
        n_tests++; if (ra !== 1'b0) begin n_fail++; $display("FAIL sd_pulse_width: ready/err after RESP got %b want 0", ra); end
        model_access(0, 3'd7, 3'd0, 64'h10, 64'd0, ed, ee);
        do_req(0, 3'd7, 3'd0, 64'h10, 64'd0, d, e, lat, b1, ra);
        n_tests++;
        if (d !== 64'h8877665544332211 || d !== ed) begin
            n_fail++; $display("FAIL ld_after_sd: got %h want %h", d, 64'h8877665544332211);
        end
    endtask

    task automatic test_byte;
        logic [63:0] d, ed;
        logic e, ee, b1, ra;
        int lat;
        model_access(0, 3'd0, 3'd1, 64'h13, 64'hAB, ed, ee);
        do_req(0, 3'd0, 3'd1, 64'h13, 64'hAB, d, e, lat, b1, ra);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", e); end
        do_req(0, 3'd1, 3'd0, 64'h13, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (d !== 64'hFFFFFFFFFFFFFFAB) begin n_fail++; $display("FAIL lb_sext: got %h want %h", d, 64'hFFFFFFFFFFFFFFAB); end
        do_req(0, 3'd2, 3'd0, 64'h13, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (d !== 64'hAB) begin n_fail++; $display("FAIL lbu_zext: got %h want %h", d, 64'hAB); end
        do_req(0, 3'd7, 3'd0, 64'h10, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (d !== 64'h88776655AB332211) begin n_fail++; $display("FAIL sb_merge: got %h want %h", d, 64'h88776655AB332211); end
    endtask

    task automatic test_errors;
        logic [63:0] d, ed;
        logic e, ee, b1, ra;
        int lat;
        do_req(0, 3'd3, 3'd0, 64'h11, 64'd0, d, e, lat, b1, ra);
        n_tests++; if ({e, d} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL lh_misaligned: got err=%b dout=%h want err=1 dout=0", e, d); end
        do_req(0, 3'd0, 3'd3, 64'h12, 64'hDEADBEEF, d, e, lat, b1, ra);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL sw_misaligned: got err=%b want 1", e); end
        do_req(0, 3'd7, 3'd0, 64'h10, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (d !== 64'h88776655AB332211) begin n_fail++; $display("FAIL err_no_write: got %h want %h", d, 64'h88776655AB332211); end
        do_req(0, 3'd7, 3'd4, 64'h18, 64'h0123456789ABCDEF, d, e, lat, b1, ra);
        n_tests++; if ({e, d} !== {1'b1, 64'd0}) begin n_fail++; $display("FAIL rd_wr_conflict: got err=%b dout=%h want err=1 dout=0", e, d); end
        model_access(0, 3'd7, 3'd0, 64'h18, 64'd0, ed, ee);
        do_req(0, 3'd7, 3'd0, 64'h18, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (d !== ed) begin n_fail++; $display("FAIL conflict_no_write: got %h want %h", d, ed); end
        do_req(0, 3'd7, 3'd0, 64'(8*DEPTH), 64'd0, d, e, lat, b1, ra);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL out_of_range: got err=%b want 1", e); end
        do_req(0, 3'd0, 3'd5, 64'h20, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_wr: got err=%b want 1", e); end
        do_req(1, 3'd7, 3'd0, BASE_B - 64'd8, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL below_base: got err=%b want 1", e); end
        do_req(1, 3'd5, 3'd0, BASE_B + 64'(8*DEPTH) - 64'd4, 64'd0, d, e, lat, b1, ra);
        model_access(1, 3'd5, 3'd0, BASE_B + 64'(8*DEPTH) - 64'd4, 64'd0, ed, ee);
        n_tests++; if ({e, d} !== {1'b0, ed}) begin n_fail++; $display("FAIL last_word_lw: got err=%b dout=%h want err=0 dout=%h", e, d, ed); end
    endtask

    // Ctrl held through the RESP edge and dropped just after it: exactly one response, at k+4.
    task automatic test_wait;
        logic [63:0] ed, got_d;
        logic ee, busy_k;
        int first, count;
        model_access(1, 3'd7, 3'd0, BASE_B + 64'h10, 64'd0, ed, ee);
        first = -1; count = 0; got_d = 'x;
        @(negedge clk);
        drive(1, 3'd7, 3'd0, BASE_B + 64'h10, 64'd0);
        @(posedge clk);
        #1 busy_k = b_busy;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (b_ready) begin
                count++;
                if (first < 0) begin first = j; got_d = b_dout; end
            end
            if (first == j && b_rd != 3'd0) begin
                @(posedge clk);
                #1 drive(1, 3'd0, 3'd0, BASE_B + 64'h10, 64'd0);
            end
        end
        n_tests++; if (busy_k !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b want 1", busy_k); end
        n_tests++; if (first != WAIT_B + 1) begin n_fail++; $display("FAIL wait_latency: got %0d want %0d", first, WAIT_B + 1); end
        n_tests++; if (count != 1) begin n_fail++; $display("FAIL wait_single_resp: got %0d responses want 1", count); end
        n_tests++; if (got_d !== ed) begin n_fail++; $display("FAIL wait_ld_data: got %h want %h", got_d, ed); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] d, ed, addr, din, base;
        logic e, ee, b1, ra;
        logic [2:0] rd, wr;
        int lat, sel, kind;
        for (int n = 0; n < 150; n++) begin
            sel  = int'($urandom_range(0, 1));
            base = (sel != 0) ? BASE_B : 64'd0;
            addr = base + 64'($urandom_range(0, DEPTH*8 + 15));
            if ($urandom_range(0, 19) == 0) addr = base - 64'($urandom_range(1, 16));
            din  = {$urandom, $urandom};
            kind = int'($urandom_range(0, 9));
            rd = 3'd0; wr = 3'd0;
            if (kind < 5)       rd = 3'($urandom_range(1, 7));
            else if (kind < 9)  wr = 3'($urandom_range(1, 4));
            else begin          rd = 3'($urandom_range(0, 7)); wr = 3'($urandom_range(1, 7)); end
            if (kind < 9 && $urandom_range(0, 1) == 1) addr = addr & ~64'(acc_size(rd, wr) - 1);
            model_access(sel, rd, wr, addr, din, ed, ee);
            do_req(sel, rd, wr, addr, din, d, e, lat, b1, ra);
            n_tests++;
            if (e !== ee) begin n_fail++; $display("FAIL rand_err[%0d]: sel=%0d rd=%0d wr=%0d a=%h got %b want %b", n, sel, rd, wr, addr, e, ee); end
            if (ee || rd != 3'd0) begin
                n_tests++;
                if (d !== ed) begin n_fail++; $display("FAIL rand_dout[%0d]: sel=%0d rd=%0d a=%h got %h want %h", n, sel, rd, addr, d, ed); end
            end
            n_tests++;
            if (lat != ((sel != 0) ? WAIT_B : 0) + 2 || ra !== 1'b0) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d tail=%b want lat=%0d tail=0", n, lat, ra, ((sel != 0) ? WAIT_B : 0) + 2);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [63:0] d, ed, old;
        logic e, ee, b1, ra, busy_w;
        int lat;
        model_access(1, 3'd7, 3'd0, BASE_B + 64'h20, 64'd0, old, ee);
        do_req(1, 3'd7, 3'd0, BASE_B + 64'h20, 64'd0, d, e, lat, b1, ra);
        @(negedge clk);
        drive(1, 3'd0, 3'd4, BASE_B + 64'h20, ~old);
        @(posedge clk);
        @(negedge clk);
        drive(1, 3'd0, 3'd0, BASE_B + 64'h20, 64'd0);
        @(posedge clk);
        #2 busy_w = b_busy;
        reset = 1'b0;
        #1;
        n_tests++; if (busy_w !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", busy_w); end
        n_tests++;
        if ({b_dout, b_ready, b_busy, b_err} !== 67'd0) begin
            n_fail++; $display("FAIL rst_mid_wait: got dout=%h rdy=%b busy=%b err=%b want all 0", b_dout, b_ready, b_busy, b_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_access(1, 3'd7, 3'd0, BASE_B + 64'h20, 64'd0, ed, ee);
        do_req(1, 3'd7, 3'd0, BASE_B + 64'h20, 64'd0, d, e, lat, b1, ra);
        n_tests++; if (d !== old || d !== ed) begin n_fail++; $display("FAIL rst_drops_store: got %h want %h", d, old); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        test_reset();
        test_init();
        test_sd_ld();
        test_byte();
        test_errors();
        test_wait();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
